// File: rtl/pt_backing_memory.sv
// ---------------------------------------------------------------------------
// pt_backing_memory
//
// Single-port read/write backing memory behind the page-table walker and the
// TLB refill path. It also stands in for main memory in unit and integration
// benches. Each request is held for a fixed number of cycles before the access
// happens. The response then stays up until the consumer accepts it. Only one
// request can be outstanding at a time.
//
// Parameters
//   DATA_W       data width in bits (a multiple of 8, at least 16)
//   DEPTH_WORDS  number of DATA_W words stored (a power of 2)
//   LATENCY      cycles spent in ACCESS per request (at least 1)
//
// Ports
//   clk               single clock, rising edge
//   rst               synchronous active-high reset
//   mem_req_valid_i   request valid
//   mem_req_ready_o   request ready, high only while idle and out of reset
//   mem_req_we_i      1 = write, 0 = read
//   mem_req_be_i      byte enables for writes (ignored on reads)
//   mem_addr_i        32-bit byte address (low offset bits are ignored)
//   mem_wdata_i       write data
//   mem_resp_valid_o  response valid
//   mem_resp_ready_i  response ready
//   mem_data_o        read data (0 for writes and for errors)
//   mem_resp_err_o    word index was beyond DEPTH_WORDS
//
// Optional feature
//   PT_BACKING_PRELOAD_EN  when defined, reset loads a small page-table image
//                          after clearing the array. Entries that fall beyond
//                          DEPTH_WORDS are skipped.
// ---------------------------------------------------------------------------
module pt_backing_memory #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_req_valid_i,
   output logic                mem_req_ready_o,
   input  logic                mem_req_we_i,
   input  logic [DATA_W/8-1:0] mem_req_be_i,
   input  logic [31:0]         mem_addr_i,
   input  logic [DATA_W-1:0]   mem_wdata_i,
   output logic                mem_resp_valid_o,
   input  logic                mem_resp_ready_i,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic                mem_resp_err_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [31:0]      DEPTH32  = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESPOND
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    cnt;
   logic [31:0]         idx_q;
   logic                we_q;
   logic [BYTES-1:0]    be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   data_q;
   logic                err_q;
   logic [DATA_W-1:0]   mem [DEPTH_WORDS];

   logic                accept;
   logic                access_now;
   logic                in_range;
   logic [AW-1:0]       arr_idx;

`ifdef PT_BACKING_PRELOAD_EN
   // Page-table image that reset writes over the cleared array. The values are
   // zero-extended or narrowed to the word width. Only indices inside the
   // array are ever asked for.
   function automatic logic [DATA_W-1:0] init_word(input int idx);
      logic [31:0] v;
      v = 32'h0;
      case (idx)
         256:     v = 32'h0000_0801;
         257:     v = 32'h1234_0007;
         512:     v = 32'h1000_000F;
         513:     v = 32'h1100_000F;
         514:     v = 32'h1200_0007;
         default: v = 32'h0;
      endcase
      return DATA_W'(v);
   endfunction
`endif

   assign accept     = mem_req_valid_i && mem_req_ready_o;
   assign access_now = (state == ACCESS) && (cnt == '0);
   // The range check uses the full 32-bit word index. A large address
   // therefore never aliases back into the array.
   assign in_range   = idx_q < DEPTH32;
   assign arr_idx    = idx_q[AW-1:0];

   assign mem_data_o     = data_q;
   assign mem_resp_err_o = err_q;

   // State register. Reset always returns to IDLE, which drops any request
   // that was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. Ready is masked during reset so that
   // nothing can be accepted while the array is being rebuilt.
   always_comb begin
      state_next       = state;
      mem_req_ready_o  = 1'b0;
      mem_resp_valid_o = 1'b0;
      case (state)
         IDLE: begin
            mem_req_ready_o = !rst;
            if (mem_req_valid_i) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            mem_resp_valid_o = 1'b1;
            if (mem_resp_ready_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and storage. The request is captured on acceptance. The counter
   // then runs down, and the array is touched only on the final ACCESS cycle.
   // A reset in the middle of a write therefore never commits it. The captured
   // response holds until the next access, which keeps it stable under
   // backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
`ifdef PT_BACKING_PRELOAD_EN
            mem[i] <= init_word(i);
`else
            mem[i] <= '0;
`endif
         end
      end else begin
         if (accept) begin
            cnt     <= CNT_LOAD;
            idx_q   <= mem_addr_i >> OFF_W;
            we_q    <= mem_req_we_i;
            be_q    <= mem_req_be_i;
            wdata_q <= mem_wdata_i;
         end else if ((state == ACCESS) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (access_now) begin
            if (!in_range) begin
               data_q <= '0;
               err_q  <= 1'b1;
            end else if (we_q) begin
               data_q <= '0;
               err_q  <= 1'b0;
               for (int b = 0; b < BYTES; b++) begin
                  if (be_q[b]) begin
                     mem[arr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                  end
               end
            end else begin
               data_q <= mem[arr_idx];
               err_q  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pt_backing_memory.sv
// ---------------------------------------------------------------------------
// tb_pt_backing_memory
//
// Drives two instances of the backing memory:
//   dut_a: 32-bit words, 1024 deep, latency 2
//   dut_b: 64-bit words, 256 deep, latency 4
// Every response is compared with a word-array model of the stored contents.
// Both instances share one reset, so any reset also reinitialises the model
// of both arrays.
// ---------------------------------------------------------------------------
module tb_pt_backing_memory;

   localparam int LAT_A = 2;
   localparam int LAT_B = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        we;
   logic [7:0]  be;
   logic [63:0] wdata;
   logic        valid_a, valid_b, rready_a, rready_b;
   logic        ready_a, rvalid_a, err_a;
   logic [31:0] data_a;
   logic        ready_b, rvalid_b, err_b;
   logic [63:0] data_b;

   int          sel;
   logic        cur_ready, cur_rvalid, cur_err;
   logic [63:0] cur_data;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] model_a [1024];
   logic [63:0] model_b [256];

   always #5 clk = ~clk;

   assign cur_ready  = (sel == 0) ? ready_a  : ready_b;
   assign cur_rvalid = (sel == 0) ? rvalid_a : rvalid_b;
   assign cur_err    = (sel == 0) ? err_a    : err_b;
   assign cur_data   = (sel == 0) ? {32'h0, data_a} : data_b;

   pt_backing_memory #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .rst(rst),
      .mem_req_valid_i(valid_a), .mem_req_ready_o(ready_a),
      .mem_req_we_i(we), .mem_req_be_i(be[3:0]),
      .mem_addr_i(addr), .mem_wdata_i(wdata[31:0]),
      .mem_resp_valid_o(rvalid_a), .mem_resp_ready_i(rready_a),
      .mem_data_o(data_a), .mem_resp_err_o(err_a)
   );

   pt_backing_memory #(.DATA_W(64), .DEPTH_WORDS(256), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst(rst),
      .mem_req_valid_i(valid_b), .mem_req_ready_o(ready_b),
      .mem_req_we_i(we), .mem_req_be_i(be),
      .mem_addr_i(addr), .mem_wdata_i(wdata),
      .mem_resp_valid_o(rvalid_b), .mem_resp_ready_i(rready_b),
      .mem_data_o(data_b), .mem_resp_err_o(err_b)
   );

   // Contents right after reset: everything is zero, plus the page-table image
   // when it is enabled. All image entries lie beyond dut_b's 256 words, so
   // dut_b always starts fully cleared.
   task automatic model_reset();
      for (int i = 0; i < 1024; i++) model_a[i] = 32'h0;
      for (int i = 0; i < 256; i++)  model_b[i] = 64'h0;
`ifdef PT_BACKING_PRELOAD_EN
      model_a[256] = 32'h0000_0801;
      model_a[257] = 32'h1234_0007;
      model_a[512] = 32'h1000_000F;
      model_a[513] = 32'h1100_000F;
      model_a[514] = 32'h1200_0007;
`endif
   endtask

   // Applies one request to the model and returns the expected response.
   task automatic model_access(input int dut, input bit w, input logic [31:0] a,
                               input logic [7:0] bm, input logic [63:0] wd,
                               output logic [63:0] rd, output bit e);
      longint unsigned bytes;
      longint unsigned depth;
      longint unsigned idx;
      bytes = (dut == 0) ? 4 : 8;
      depth = (dut == 0) ? 1024 : 256;
      idx   = longint'(a) / bytes;
      rd    = 64'h0;
      e     = 1'b0;
      if (idx >= depth) begin
         e = 1'b1;
      end else if (w) begin
         for (int k = 0; k < int'(bytes); k++) begin
            if (bm[k]) begin
               if (dut == 0) model_a[int'(idx)][8*k +: 8] = wd[8*k +: 8];
               else          model_b[int'(idx)][8*k +: 8] = wd[8*k +: 8];
            end
         end
      end else begin
         rd = (dut == 0) ? {32'h0, model_a[int'(idx)]} : model_b[int'(idx)];
      end
   endtask

   // Runs one request/response pair on the selected instance. It reports the
   // observed response, the acceptance-to-valid latency, whether data and err
   // stayed stable while the response was held off, and whether the handshake
   // returned the block to ready.
   task automatic do_txn(input int dut, input bit w, input logic [31:0] a,
                         input logic [7:0] bm, input logic [63:0] wd,
                         input int hold, input bit early,
                         output logic [63:0] rd, output bit e, output int lat,
                         output bit ready_dropped, output bit stable,
                         output bit done_ok, output bit timeout, output time t_acc);
      int n;
      sel = dut;
      timeout = 1'b0;
      stable  = 1'b1;
      addr = a; we = w; be = bm; wdata = wd;
      if (dut == 0) rready_a = early; else rready_b = early;
      #0;
      n = 0;
      while (!cur_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) timeout = 1'b1;
      if (dut == 0) valid_a = 1'b1; else valid_b = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      valid_a = 1'b0; valid_b = 1'b0;
      ready_dropped = !cur_ready;
      lat = 0;
      while (!cur_rvalid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      if (lat >= 50) timeout = 1'b1;
      rd = cur_data;
      e  = cur_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!cur_rvalid || cur_data !== rd || cur_err !== e || cur_ready !== 1'b0)
            stable = 1'b0;
      end
      if (dut == 0) rready_a = 1'b1; else rready_b = 1'b1;
      @(posedge clk); #1;
      rready_a = 1'b0; rready_b = 1'b0;
      done_ok = !cur_rvalid && cur_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({ready_a, rvalid_a, err_a, data_a} !== 35'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_a {ready,rvalid,err,data}: got %h expected 0",
                  {ready_a, rvalid_a, err_a, data_a});
      end
      tests_run++;
      if ({ready_b, rvalid_b, err_b, data_b} !== 67'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_b {ready,rvalid,err,data}: got %h expected 0",
                  {ready_b, rvalid_b, err_b, data_b});
      end
      rst = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if ({ready_a, ready_b} !== 2'b11) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_ready: got %b expected 11", {ready_a, ready_b});
      end
   endtask

   task automatic test_preload();
      logic [31:0] addrs [6] = '{32'h400, 32'h404, 32'h808, 32'h80C, 32'h800, 32'h403};
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t;
      for (int i = 0; i < 6; i++) begin
         model_access(0, 1'b0, addrs[i], 8'h0, 64'h0, exp, ee);
         do_txn(0, 1'b0, addrs[i], 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
         tests_run++;
         if ({rd, e} !== {exp, ee}) begin
            tests_failed++;
            $display("[TB] FAIL preload_read addr=%h: got data=%h err=%b expected data=%h err=%b",
                     addrs[i], rd, e, exp, ee);
         end
         tests_run++;
         if ({lat, rdrop, dn, to} !== {LAT_A, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL preload_timing addr=%h: got lat=%0d rdrop=%b done=%b to=%b expected lat=%0d 1 1 0",
                     addrs[i], lat, rdrop, dn, to, LAT_A);
         end
      end
   endtask

   task automatic test_byte_write();
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t;
      model_access(0, 1'b1, 32'h100, 8'h05, 64'hDEADBEEF, exp, ee);
      do_txn(0, 1'b1, 32'h100, 8'h05, 64'hDEADBEEF, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e, dn} !== {64'h0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL bw_write_resp: got data=%h err=%b done=%b expected 0 0 1", rd, e, dn);
      end
      model_access(0, 1'b0, 32'h100, 8'h0, 64'h0, exp, ee);
      do_txn(0, 1'b0, 32'h100, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {64'h00AD00EF, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL bw_masked_read: got %h err=%b expected 00ad00ef err=0", rd, e);
      end
      model_access(0, 1'b1, 32'h102, 8'h0F, 64'h11223344, exp, ee);
      do_txn(0, 1'b1, 32'h102, 8'h0F, 64'h11223344, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      do_txn(0, 1'b0, 32'h100, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {64'h11223344, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL bw_misaligned_read: got %h err=%b expected 11223344 err=0", rd, e);
      end
      model_access(0, 1'b1, 32'h100, 8'h00, 64'hFFFFFFFF, exp, ee);
      do_txn(0, 1'b1, 32'h100, 8'h00, 64'hFFFFFFFF, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e, dn} !== {64'h0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL bw_be0_resp: got data=%h err=%b done=%b expected 0 0 1", rd, e, dn);
      end
      do_txn(0, 1'b0, 32'h100, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if (rd !== 64'h11223344) begin
         tests_failed++;
         $display("[TB] FAIL bw_be0_noop: got %h expected 11223344", rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [6] = '{32'h1000, 32'h10000, 32'hFFC, 32'hFFFFFFFC, 32'hFFC, 32'hFFC};
      bit          wes   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t;
      for (int i = 0; i < 6; i++) begin
         model_access(0, wes[i], addrs[i], 8'h0F, 64'hA5A5_5A5A, exp, ee);
         do_txn(0, wes[i], addrs[i], 8'h0F, 64'hA5A5_5A5A, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
         tests_run++;
         if ({rd, e, dn, to} !== {exp, ee, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL oor addr=%h we=%b: got data=%h err=%b done=%b to=%b expected data=%h err=%b 1 0",
                     addrs[i], wes[i], rd, e, dn, to, exp, ee);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t;
      model_access(0, 1'b1, 32'h204, 8'h0F, 64'hCAFEF00D, exp, ee);
      do_txn(0, 1'b1, 32'h204, 8'h0F, 64'hCAFEF00D, 5, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      model_access(0, 1'b0, 32'h204, 8'h0, 64'h0, exp, ee);
      do_txn(0, 1'b0, 32'h204, 8'h0, 64'h0, 5, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({st, dn, rd, e} !== {1'b1, 1'b1, exp, ee}) begin
         tests_failed++;
         $display("[TB] FAIL backpressure: got stable=%b done=%b data=%h err=%b expected 1 1 %h %b",
                  st, dn, rd, e, exp, ee);
      end
      do_txn(0, 1'b0, 32'h2000, 8'h0, 64'h0, 5, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({st, dn, rd, e} !== {1'b1, 1'b1, 64'h0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL backpressure_err: got stable=%b done=%b data=%h err=%b expected 1 1 0 1",
                  st, dn, rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t, t_prev;
      logic [31:0] a;
      for (int i = 0; i < 6; i++) begin
         a = {$urandom_range(0, 1023), 2'b00};
         model_access(0, i[0], a, 8'h0F, {32'h0, $urandom}, exp, ee);
         do_txn(0, i[0], a, 8'h0F, wdata, 0, 1'b1, rd, e, lat, rdrop, st, dn, to, t);
         tests_run++;
         if ({rd, e} !== {exp, ee}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_data addr=%h: got %h err=%b expected %h err=%b", a, rd, e, exp, ee);
         end
         if (i > 0) begin
            tests_run++;
            if ((t - t_prev) !== time'((LAT_A + 2) * 10)) begin
               tests_failed++;
               $display("[TB] FAIL b2b_spacing: got %0t expected %0d", t - t_prev, (LAT_A + 2) * 10);
            end
         end
         t_prev = t;
      end
   endtask

   task automatic test_wide();
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to;
      int lat;
      time t;
      do_txn(1, 1'b0, 32'h800, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e, lat} !== {64'h0, 1'b1, LAT_B}) begin
         tests_failed++;
         $display("[TB] FAIL wide_oor: got data=%h err=%b lat=%0d expected 0 1 %0d", rd, e, lat, LAT_B);
      end
      model_access(1, 1'b1, 32'h7F8, 8'hF0, 64'h0123456789ABCDEF, exp, ee);
      do_txn(1, 1'b1, 32'h7F8, 8'hF0, 64'h0123456789ABCDEF, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      do_txn(1, 1'b0, 32'h7F8, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {64'h0123456700000000, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL wide_masked_read: got %h err=%b expected 0123456700000000 err=0", rd, e);
      end
   endtask

   task automatic test_random(input int dut, input int count);
      logic [63:0] rd, exp, wd;
      logic [31:0] a;
      logic [7:0]  bm;
      bit e, ee, rdrop, st, dn, to, w, early;
      int lat, hold, span;
      time t;
      span = (dut == 0) ? 4096 : 2048;
      for (int i = 0; i < count; i++) begin
         a     = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, span - 1));
         w     = 1'($urandom_range(0, 1));
         bm    = 8'($urandom);
         wd    = {$urandom, $urandom};
         early = 1'($urandom_range(0, 1));
         hold  = early ? 0 : $urandom_range(0, 2);
         if (dut == 0) wd[63:32] = 32'h0;
         model_access(dut, w, a, bm, wd, exp, ee);
         do_txn(dut, w, a, bm, wd, hold, early, rd, e, lat, rdrop, st, dn, to, t);
         tests_run++;
         if ({rd, e} !== {exp, ee}) begin
            tests_failed++;
            $display("[TB] FAIL rand%0d_data addr=%h we=%b be=%h: got %h err=%b expected %h err=%b",
                     dut, a, w, bm, rd, e, exp, ee);
         end
         tests_run++;
         if ({lat, st, dn, to} !== {(dut == 0) ? LAT_A : LAT_B, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL rand%0d_hs addr=%h: got lat=%0d stable=%b done=%b to=%b", dut, a, lat, st, dn, to);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] rd, exp;
      bit e, ee, rdrop, st, dn, to, saw_valid;
      int lat;
      time t;
      sel = 1;
      addr = 32'h200; we = 1'b1; be = 8'hFF; wdata = 64'h5555_AAAA_5555_AAAA;
      rready_b = 1'b1;
      valid_b  = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({ready_b, rvalid_b} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL midop_in_access: got ready=%b rvalid=%b expected 0 0", ready_b, rvalid_b);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if ({ready_b, rvalid_b} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL midop_idle_after_reset: got ready=%b rvalid=%b expected 1 0", ready_b, rvalid_b);
      end
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rvalid_b) saw_valid = 1'b1;
      end
      rready_b = 1'b0;
      tests_run++;
      if (saw_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midop_no_response: got rvalid seen=%b expected 0", saw_valid);
      end
      model_access(1, 1'b0, 32'h200, 8'h0, 64'h0, exp, ee);
      do_txn(1, 1'b0, 32'h200, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {exp, ee}) begin
         tests_failed++;
         $display("[TB] FAIL midop_read_200: got %h err=%b expected %h err=%b", rd, e, exp, ee);
      end
      model_access(0, 1'b0, 32'h100, 8'h0, 64'h0, exp, ee);
      do_txn(0, 1'b0, 32'h100, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {exp, ee}) begin
         tests_failed++;
         $display("[TB] FAIL midop_cleared_a: got %h err=%b expected %h err=%b", rd, e, exp, ee);
      end
      model_access(0, 1'b0, 32'h400, 8'h0, 64'h0, exp, ee);
      do_txn(0, 1'b0, 32'h400, 8'h0, 64'h0, 0, 1'b0, rd, e, lat, rdrop, st, dn, to, t);
      tests_run++;
      if ({rd, e} !== {exp, ee}) begin
         tests_failed++;
         $display("[TB] FAIL midop_preload_a: got %h err=%b expected %h err=%b", rd, e, exp, ee);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      sel = 0;
      addr = 32'h0; we = 1'b0; be = 8'h0; wdata = 64'h0;
      valid_a = 1'b0; valid_b = 1'b0; rready_a = 1'b0; rready_b = 1'b0;
      test_reset();
      test_preload();
      test_byte_write();
      test_out_of_range();
      test_backpressure();
      test_back_to_back();
      test_wide();
      test_random(0, 80);
      test_random(1, 40);
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
